demux_stream_router: RTL
========================

Name: demux_stream_router

Overview:
- Packet-level controller that steers one valid/ready input stream to one of NUM_OUT output lanes, in the manner of a 1xN demultiplexer.
- The destination is latched on the first beat of each packet and held until the last beat.
- Packets whose destination is out of range are discarded and counted.
- Sits between a single producer and NUM_OUT consumers. It is the sequencing/ownership layer around the demux select.

Parameters:
- DATA_W, 8, data beat width in bits
- NUM_OUT, 3, number of output lanes (2..2^DEST_W)
- DEST_W, 2, width of the destination field

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_data  input  DATA_W  input beat payload
- in_dest  input  DEST_W  destination lane; sampled only on the first beat of a packet
- in_last  input  1  marks the final beat of a packet
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- out_data  output  NUM_OUT*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- out_last  output  NUM_OUT  per-lane last flag
- out_valid  output  NUM_OUT  per-lane valid
- out_ready  input  NUM_OUT  per-lane ready
- busy  output  1  high while a packet is in progress or the holding register is occupied
- drop_count  output  16  saturating count of dropped packets

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, hold_valid=0, hold_dest=0, hold_data=0, hold_last=0, drop_count=0.
  - in_ready is forced 0 while rst_n is low.
  - A reset mid-packet abandons the packet. No output beat survives reset.
- Datapath: a single holding register (hold_data, hold_last, hold_dest, hold_valid).
  - out_valid[i] = hold_valid && hold_dest==i.
  - out_data lane i = hold_data when hold_dest==i, otherwise 0. out_last lane i uses the same rule.
  - Exactly one lane can be valid at a time. Latency from input accept to out_valid is 1 cycle.
- drain = hold_valid && out_ready[hold_dest].
- in_ready (rst_n high): 1 in DROP; otherwise !hold_valid || drain. No bubble under continuous ready, so throughput is 1 beat/cycle.
- Holding register update per cycle:
  - Routed beat accepted: load the beat, hold_valid=1. This takes priority over drain, so drain and load in the same cycle is legal.
  - Else if drain: hold_valid=0.
  - Once out_valid is asserted, it and its payload stay stable until that lane's out_ready.
- FSM:
  - IDLE: on an accepted beat, if in_dest<NUM_OUT then pkt_dest=in_dest, the beat is routed, and next state is ROUTE unless in_last. If in_dest>=NUM_OUT the beat is discarded, drop_count increments (saturating at 16'hFFFF), and next state is DROP unless in_last. A single-beat packet stays in IDLE.
  - ROUTE: in_dest is ignored. Every accepted beat goes to pkt_dest. The accepted beat with in_last returns to IDLE.
  - DROP: in_ready=1 and beats are discarded. The accepted beat with in_last returns to IDLE. drop_count is not incremented again.
- Back-to-back packets to different lanes: a new packet may be accepted in IDLE in the same cycle the previous packet's last beat drains from the hold register.
- busy = (state!=IDLE) || hold_valid.
- Input stall, in_valid low mid-packet: state and pkt_dest are held indefinitely.
- out_ready of non-selected lanes has no effect.

Test Plan:
- Reset, then packet dest=1, beats 0xA1,0xA2(last), all out_ready=1 -> out_valid=3'b010 on cycles 1 and 2 with data 0xA1, 0xA2, out_last on the second; lanes 0 and 2 read 0; busy falls after the drain; drop_count=0.
- Packet dest=2, 3 beats, in_dest toggled to 0 on beats 2-3 -> all three beats appear on lane 2 only.
- Packet dest=0 with out_ready[0]=0 for 4 cycles -> in_ready=0 once hold is full; lane 0 holds 0x11 stable; beats resume 1/cycle after out_ready[0]=1; no beat lost or duplicated.
- Packet dest=3 (>=NUM_OUT), 4 beats -> in_ready=1 throughout; no out_valid; drop_count=1; the following packet dest=0 is routed normally.
- Back-to-back single-beat packets dest=0,1,2,0 with all ready -> one beat/cycle; out_valid sequence 001,010,100,001.
- rst_n low for 1 cycle mid-way through a 4-beat dest=1 packet -> out_valid=0, state IDLE, drop_count=0; the next first beat is routed by its own in_dest.

Source files
------------

// File: rtl/demux_stream_router.sv
// 1xN packet demux: latches destination on first beat, steers to one lane.
// Out-of-range packets are swallowed and counted.
module demux_stream_router #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 3,
  parameter int DEST_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [DEST_W-1:0]         in_dest,
  input  logic                      in_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic                      busy,
  output logic [15:0]               drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUTE,
    S_DROP
  } state_t;

  localparam logic [DEST_W:0] LP_NUM =
    (DEST_W+1)'(NUM_OUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DEST_W-1:0]   r_pkt_dest;
  logic                r_hold_valid;
  logic [DEST_W-1:0]   r_hold_dest;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_hold_last;
  logic [15:0]         r_drop_count;

  logic                w_drain;
  logic                w_in_ready;
  logic                w_acc;
  logic                w_in_range;
  logic                w_route;
  logic                w_drop_new;
  logic [DEST_W-1:0]   w_dest;

  // hold_dest is always in range while hold_valid is set
  always_comb begin
    w_drain = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (r_hold_dest == DEST_W'(i) && out_ready[i])
        w_drain = r_hold_valid;
    end
  end

  assign w_in_ready = rst_n &&
    (r_state == S_DROP || !r_hold_valid || w_drain);
  assign w_acc      = in_valid && w_in_ready;
  assign w_in_range = {1'b0, in_dest} < LP_NUM;

  always_comb begin
    w_state_nxt = r_state;
    w_route     = 1'b0;
    w_drop_new  = 1'b0;
    w_dest      = r_pkt_dest;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_in_range) begin
            w_route = 1'b1;
            w_dest  = in_dest;
            if (!in_last) w_state_nxt = S_ROUTE;
          end else begin
            w_drop_new = 1'b1;
            if (!in_last) w_state_nxt = S_DROP;
          end
        end
      end
      S_ROUTE: begin
        if (w_acc) begin
          w_route = 1'b1;
          if (in_last) w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_acc && in_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // a load takes priority over drain so the hold reg never bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pkt_dest   <= '0;
      r_hold_valid <= 1'b0;
      r_hold_dest  <= '0;
      r_hold_data  <= '0;
      r_hold_last  <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_route) begin
        r_pkt_dest   <= w_dest;
        r_hold_dest  <= w_dest;
        r_hold_data  <= in_data;
        r_hold_last  <= in_last;
        r_hold_valid <= 1'b1;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
      if (w_drop_new && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  always_comb begin
    out_data  = '0;
    out_last  = '0;
    out_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (r_hold_dest == DEST_W'(i)) begin
        out_data[i*DATA_W +: DATA_W] = r_hold_data;
        out_last[i]  = r_hold_last;
        out_valid[i] = r_hold_valid;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign busy       = (r_state != S_IDLE) || r_hold_valid;
  assign drop_count = r_drop_count;

endmodule
